adc_capture: RTL

Parametrised ADC capture front-end for the chip's digital shell. Generates a programmable ADC sample clock and captures a multi-channel parallel ADC word on each sample. Serialises the channels into a tagged ready/valid stream through an internal FIFO, for consumption by an MMIO or DMA reader. Successor to the fixed single-channel 8-bit adc_clock/adc_data pair: adds width, channel count, FIFO depth, clock divider, overflow detection and flush.

---
 rtl/adc_capture_pkg.sv | 10 +
 rtl/adc_capture_fifo.sv | 53 +++++
 rtl/adc_capture.sv | 103 ++++++++++
 3 files changed

// File: rtl/adc_capture_pkg.sv
// adc_capture_pkg: shared serialiser state type and width helper for the ADC capture front-end
package adc_capture_pkg;

    typedef enum logic {IDLE, PUSH} ser_state_t;

    function automatic int clog2_min1(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/adc_capture_fifo.sv
// adc_capture_fifo: synchronous FIFO with push/pop/clear, occupancy count and combinational head read
module adc_capture_fifo #(
    parameter int W     = 8,
    parameter int DEPTH = 16
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   clear,
    input  logic                   push,
    input  logic                   pop,
    input  logic [W-1:0]           din,
    output logic [W-1:0]           head,
    output logic [$clog2(DEPTH):0] count,
    output logic                   empty,
    output logic                   push_ok
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic          full;
    logic          pop_ok;

    assign full    = count == (AW+1)'(DEPTH);
    assign empty   = count == '0;
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);
    assign head    = mem[rd_ptr];

    // pointers and occupancy; clear overrides any same-cycle push or pop
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pop_ok) rd_ptr <= rd_ptr + 1'b1;
            count <= count + (AW+1)'(push_ok) - (AW+1)'(pop_ok);
        end
    end

    // storage is not reset; only entries between the pointers are ever observed
    always_ff @(posedge clk) begin
        if (push_ok && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/adc_capture.sv
// adc_capture: ADC sample-clock divider, multi-channel capture and serialised tagged output stream
module adc_capture
    import adc_capture_pkg::*;
#(
    parameter int  DATA_W   = 8,
    parameter int  CHANNELS = 1,
    parameter int  DEPTH    = 16,
    parameter int  DIV_W    = 8,
    localparam int CH_W     = clog2_min1(CHANNELS)
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       cfg_enable,
    input  logic [DIV_W-1:0]           cfg_div,
    input  logic                       cfg_clear,
    output logic                       adc_clock,
    input  logic [CHANNELS*DATA_W-1:0] adc_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [DATA_W-1:0]          out_bits,
    output logic [CH_W-1:0]            out_chan,
    output logic [$clog2(DEPTH):0]     fifo_count,
    output logic                       overflow
);
    localparam int WW = CH_W + DATA_W;

    logic [DIV_W-1:0]           cnt;
    logic                       wrap;
    logic                       strobe;
    ser_state_t                 state;
    logic [CH_W-1:0]            idx;
    logic [CHANNELS*DATA_W-1:0] hold;
    logic [DATA_W-1:0]          cur;
    logic                       push;
    logic                       push_ok;
    logic                       fifo_empty;
    logic [WW-1:0]              head;

    assign wrap      = cfg_enable && cnt == cfg_div;
    assign strobe    = wrap && adc_clock;
    assign push      = state == PUSH;
    assign cur       = hold[int'(idx)*DATA_W +: DATA_W];
    assign out_valid = !fifo_empty;
    assign out_bits  = head[DATA_W-1:0];
    assign out_chan  = out_valid ? head[WW-1:DATA_W] : '0;

    // sample-clock divider: half-period of cfg_div+1 cycles, held low while disabled
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= '0;
            adc_clock <= 1'b0;
        end else if (!cfg_enable) begin
            cnt       <= '0;
            adc_clock <= 1'b0;
        end else if (wrap) begin
            cnt       <= '0;
            adc_clock <= !adc_clock;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // capture on adc_clock fall, then push one channel per cycle; drops set the sticky overflow
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            idx      <= '0;
            hold     <= '0;
            overflow <= 1'b0;
        end else if (cfg_clear) begin
            state    <= IDLE;
            idx      <= '0;
            overflow <= 1'b0;
        end else begin
            if ((strobe && push) || (push && !push_ok)) overflow <= 1'b1;
            if (strobe && !push) begin
                state <= PUSH;
                idx   <= '0;
                hold  <= adc_data;
            end else if (push) begin
                state <= (idx == CH_W'(CHANNELS - 1)) ? IDLE : PUSH;
                idx   <= idx + 1'b1;
            end
        end
    end

    adc_capture_fifo #(
        .W     (WW),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear   (cfg_clear),
        .push    (push),
        .pop     (out_valid && out_ready),
        .din     ({idx, cur}),
        .head    (head),
        .count   (fifo_count),
        .empty   (fifo_empty),
        .push_ok (push_ok)
    );

endmodule
